// File: rtl/lighting_pkg.sv
// Shared constants and helpers for the time-of-day lighting controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents: time-field limits, hour-band boundaries, LED patterns per band,
// PWM duty levels for the dimmed build, and the 7-segment digit decoder.
package lighting_pkg;

    localparam logic [5:0] MAX_SEC  = 6'd59;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [4:0] MAX_HOUR = 5'd23;

    // Band boundaries: DAY starts 06:00, EVENING 18:00, NIGHT 22:00 (wraps to 05:59).
    localparam logic [4:0] DAY_START_HOUR     = 5'd6;
    localparam logic [4:0] EVENING_START_HOUR = 5'd18;
    localparam logic [4:0] NIGHT_START_HOUR   = 5'd22;

    localparam logic [15:0] LEDS_DAY     = 16'h0000;
    localparam logic [15:0] LEDS_EVENING = 16'h00FF;
    localparam logic [15:0] LEDS_NIGHT   = 16'hFFFF;

    // LED is on while the free-running PWM counter is below the duty value.
    localparam logic [7:0] PWM_DUTY_EVENING = 8'd128;
    localparam logic [7:0] PWM_DUTY_NIGHT   = 8'd64;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        BAND_DAY     = 2'd0,
        BAND_EVENING = 2'd1,
        BAND_NIGHT   = 2'd2
    } band_t;

    function automatic band_t hour_band(input logic [4:0] hr);
        if (hr >= DAY_START_HOUR && hr < EVENING_START_HOUR) begin
            return BAND_DAY;
        end
        if (hr >= EVENING_START_HOUR && hr < NIGHT_START_HOUR) begin
            return BAND_EVENING;
        end
        return BAND_NIGHT;
    endfunction

    function automatic logic [15:0] band_pattern(input band_t band);
        case (band)
            BAND_DAY:     return LEDS_DAY;
            BAND_EVENING: return LEDS_EVENING;
            default:      return LEDS_NIGHT;
        endcase
    endfunction

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debounce, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse cycle.
// Backpressure: none; one pulse per accepted press, holding the button gives no repeats.
//
// Ports: clk, rst_n (synchronous, active-low), btn (async level), pulse (one-cycle press strobe).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       btn_sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The synchronised level has differed from the accepted level for DEBOUNCE_CYCLES cycles.
    assign accept = (btn_sync[1] != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_sync <= 2'b00;
            stable   <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], btn};
            // Any cycle that agrees with the accepted level restarts the stability window.
            if (btn_sync[1] == stable) begin
                cnt <= '0;
            end else if (accept) begin
                cnt    <= '0;
                stable <= btn_sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
            pulse <= accept && btn_sync[1];
        end
    end

endmodule

// File: rtl/lighting_system_top.sv
// Time-of-day LED lighting controller: 24 h clock, button setting, 4-digit scan, hour-band LEDs.
// Latency: outputs registered, o_leds/o_seg follow the time registers by one cycle.
// Backpressure: none; buttons are free-running inputs, display and LEDs are continuous outputs.
//
// Ports: i_clk, i_rst (sync active-low), i_btn_hours / i_btn_minutes (async, active-high),
//        o_seg {g,f,e,d,c,b,a} active-low, o_an active-low (an[0]=minute units .. an[3]=hour tens),
//        o_leds active-high.
// Build option: define LED_PWM_DIM_EN to dim lit LEDs with an 8-bit PWM (EVENING 128/256, NIGHT 64/256).
module lighting_system_top
    import lighting_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 10_000,
    parameter int REFRESH_CYCLES  = 50_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_hours,
    input  logic        i_btn_minutes,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_an,
    output logic [15:0] o_leds
);

    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [REF_W-1:0]   REFRESH_LAST = REF_W'(REFRESH_CYCLES - 1);

    logic [PRESC_W-1:0] presc;
    logic [REF_W-1:0]   refresh_cnt;
    logic [1:0]         digit_idx;
    logic [3:0]         digit;
    logic [5:0]         seconds;
    logic [5:0]         minutes;
    logic [4:0]         hours;
    logic               tick;
    logic               min_press;
    logic               hr_press;
    logic               min_carry;
    logic               hr_carry;
    logic               min_step;
    logic               hr_step;
    band_t              band;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_minutes (
        .clk   (i_clk),
        .rst_n (i_rst),
        .btn   (i_btn_minutes),
        .pulse (min_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hours (
        .clk   (i_clk),
        .rst_n (i_rst),
        .btn   (i_btn_hours),
        .pulse (hr_press)
    );

    assign tick      = (presc == PRESC_LAST);
    assign min_carry = tick && (seconds == MAX_SEC);
    // A minute press coinciding with the seconds carry still moves minutes by one,
    // and a minute press never carries into hours.
    assign min_step  = min_press || min_carry;
    assign hr_carry  = min_carry && !min_press && (minutes == MAX_MIN);
    assign hr_step   = hr_press || hr_carry;
    assign band      = hour_band(hours);

    always_comb begin
        digit = 4'd0;
        case (digit_idx)
            2'd0:    digit = 4'(minutes % 6'd10);
            2'd1:    digit = 4'(minutes / 6'd10);
            2'd2:    digit = 4'(hours % 5'd10);
            default: digit = 4'(hours / 5'd10);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            presc       <= '0;
            seconds     <= '0;
            minutes     <= '0;
            hours       <= '0;
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            o_seg       <= SEG_BLANK;
            o_an        <= 4'hF;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;

            if (min_press) begin
                seconds <= '0;
            end else if (tick) begin
                seconds <= (seconds == MAX_SEC) ? '0 : seconds + 1'b1;
            end

            if (min_step) begin
                minutes <= (minutes == MAX_MIN) ? '0 : minutes + 1'b1;
            end

            if (hr_step) begin
                hours <= (hours == MAX_HOUR) ? '0 : hours + 1'b1;
            end

            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            o_an  <= ~(4'b0001 << digit_idx);
            o_seg <= seg_decode(digit);
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] duty;

    always_comb begin
        duty = 8'd0;
        case (band)
            BAND_EVENING: duty = PWM_DUTY_EVENING;
            BAND_NIGHT:   duty = PWM_DUTY_NIGHT;
            default:      duty = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pwm_cnt <= 8'd0;
            o_leds  <= LEDS_DAY;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            o_leds  <= (pwm_cnt < duty) ? band_pattern(band) : LEDS_DAY;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_leds <= LEDS_DAY;
        end else begin
            o_leds <= band_pattern(band);
        end
    end
`endif

endmodule

// File: tb/tb_lighting_system_top.sv
module tb_lighting_system_top;

    localparam int F   = 100;
    localparam int DB  = 32;
    localparam int REF = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_h = 1'b0;
    logic        btn_m = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] leds;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tod     = 0;
    int m_done  = 0;

    lighting_system_top #(
        .CLK_FREQ_HZ     (F),
        .DEBOUNCE_CYCLES (DB),
        .REFRESH_CYCLES  (REF)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_btn_hours   (btn_h),
        .i_btn_minutes (btn_m),
        .o_seg         (seg),
        .o_an          (an),
        .o_leds        (leds)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; a one-second tick lands on every F-th edge.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model: time of day in seconds ----------------
    task automatic model_advance();
        while (m_done < cyc) begin
            m_done++;
            if (m_done % F == 0) tod = (tod + 1) % 86400;
        end
    endtask

    function automatic int m_hr();
        return tod / 3600;
    endfunction

    function automatic int m_min();
        return (tod / 60) % 60;
    endfunction

    task automatic model_min_press();
        tod = m_hr() * 3600 + ((m_min() + 1) % 60) * 60;
    endtask

    task automatic model_hr_press();
        tod = ((m_hr() + 1) % 24) * 3600 + (tod % 3600);
    endtask

    function automatic logic [15:0] exp_leds(input int h);
        if (h >= 6 && h < 18)  return 16'h0000;
        if (h >= 18 && h < 22) return 16'h00FF;
        return 16'hFFFF;
    endfunction

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int seg_val(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (digit_seg(i) === s) return i;
        end
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_phase(input int p);
        bit found = 1'b0;
        for (int i = 0; i < F + 2; i++) begin
            @(negedge clk);
            if (cyc % F == p) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_phase: phase %0d not reached, cyc=%0d", p, cyc);
        end
    endtask

    // Press starts just after a tick so the debounced pulse lands well before the next one.
    task automatic press(input bit do_min, input bit do_hr, input int hold);
        wait_phase(2);
        model_advance();
        if (do_min) model_min_press();
        if (do_hr)  model_hr_press();
        btn_m = do_min;
        btn_h = do_hr;
        repeat (hold) @(negedge clk);
        btn_m = 1'b0;
        btn_h = 1'b0;
        repeat (DB + 6) @(negedge clk);
    endtask

    function automatic int rand_hold();
        return int'($urandom_range(DB + 20, DB + 8));
    endfunction

    task automatic read_display(output int hr, output int mn, output logic [6:0] s0,
                                output logic [6:0] s1, output logic [15:0] l);
        logic [6:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = 7'h7F;
        wait_phase(45);
        model_advance();
        for (int k = 0; k < 4 * REF + 4; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: s[0] = seg;
                4'b1101: s[1] = seg;
                4'b1011: s[2] = seg;
                4'b0111: s[3] = seg;
                default: ;
            endcase
        end
        if (seg_val(s[3]) < 0 || seg_val(s[2]) < 0) hr = -1;
        else hr = seg_val(s[3]) * 10 + seg_val(s[2]);
        if (seg_val(s[1]) < 0 || seg_val(s[0]) < 0) mn = -1;
        else mn = seg_val(s[1]) * 10 + seg_val(s[0]);
        s0 = s[0];
        s1 = s[1];
        l  = leds;
    endtask

    task automatic set_time(input int h, input int m);
        model_advance();
        for (int i = 0; i < 30 && m_hr() != h; i++) begin
            press(1'b0, 1'b1, rand_hold());
            model_advance();
        end
        for (int i = 0; i < 70 && m_min() != m; i++) begin
            press(1'b1, 1'b0, rand_hold());
            model_advance();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
        n_tests++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
        n_tests++; if (leds !== 16'h0000) begin n_fail++; $display("FAIL reset_leds: got %h want 0000", leds); end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        tod = 0;
        m_done = 0;
        @(negedge clk);
        n_tests++; if (an !== 4'b1110) begin n_fail++; $display("FAIL post_reset_an: got %b want 1110", an); end
        n_tests++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL post_reset_seg: got %b want 1000000", seg); end
        n_tests++; if (leds !== 16'hFFFF) begin n_fail++; $display("FAIL post_reset_leds: got %h want ffff", leds); end
    endtask

    task automatic test_minutes();
        int hr, mn; logic [6:0] s0, s1; logic [15:0] l;
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, rand_hold());
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (mn !== 5) begin n_fail++; $display("FAIL minutes_5: got %0d want 5", mn); end
        n_tests++; if (hr !== 0) begin n_fail++; $display("FAIL minutes_hr: got %0d want 0", hr); end
        n_tests++; if (s0 !== 7'b0010010) begin n_fail++; $display("FAIL minutes_seg0: got %b want 0010010", s0); end
        n_tests++; if (s1 !== 7'b1000000) begin n_fail++; $display("FAIL minutes_seg1: got %b want 1000000", s1); end
    endtask

    task automatic test_hours();
        int hr, mn, want_min; logic [6:0] s0, s1; logic [15:0] l;
        press(1'b0, 1'b1, 300);
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 1) begin n_fail++; $display("FAIL hold_hours: got %0d want 1", hr); end
        n_tests++; if (mn !== m_min()) begin n_fail++; $display("FAIL hold_minutes: got %0d want %0d", mn, m_min()); end
        for (int i = 0; i < 17; i++) press(1'b0, 1'b1, rand_hold());
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 18) begin n_fail++; $display("FAIL hours_18: got %0d want 18", hr); end
        n_tests++; if (l !== 16'h00FF) begin n_fail++; $display("FAIL leds_evening: got %h want 00ff", l); end
        for (int i = 0; i < 6; i++) press(1'b0, 1'b1, rand_hold());
        read_display(hr, mn, s0, s1, l);
        want_min = m_min();
        n_tests++; if (hr !== 0) begin n_fail++; $display("FAIL hours_wrap: got %0d want 0", hr); end
        n_tests++; if (mn !== want_min) begin n_fail++; $display("FAIL hours_wrap_min: got %0d want %0d", mn, want_min); end
        n_tests++; if (l !== 16'hFFFF) begin n_fail++; $display("FAIL leds_night: got %h want ffff", l); end
    endtask

    task automatic test_debounce();
        int hr, mn; logic [6:0] s0, s1; logic [15:0] l;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(50, 30)) @(negedge clk);
            btn_m = 1'b1;
            repeat ($urandom_range(20, 1)) @(negedge clk);
            btn_m = 1'b0;
        end
        repeat (DB + 6) @(negedge clk);
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (mn !== m_min()) begin n_fail++; $display("FAIL glitch_min: got %0d want %0d", mn, m_min()); end
        n_tests++; if (hr !== m_hr()) begin n_fail++; $display("FAIL glitch_hr: got %0d want %0d", hr, m_hr()); end
    endtask

    task automatic test_rollover();
        int hr, mn; logic [6:0] s0, s1; logic [15:0] l;
        set_time(5, 59);
        repeat (60 * F) @(negedge clk);
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 6 || mn !== 0) begin n_fail++; $display("FAIL roll_0600: got %0d:%0d want 6:0", hr, mn); end
        n_tests++; if (l !== 16'h0000) begin n_fail++; $display("FAIL leds_day: got %h want 0000", l); end
        set_time(23, 59);
        repeat (58 * F) @(negedge clk);
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 23 || mn !== 59) begin n_fail++; $display("FAIL at_235959: got %0d:%0d want 23:59", hr, mn); end
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 0 || mn !== 0) begin n_fail++; $display("FAIL roll_midnight: got %0d:%0d want 0:0", hr, mn); end
        n_tests++; if (hr !== m_hr() || mn !== m_min()) begin n_fail++; $display("FAIL roll_model: got %0d:%0d want %0d:%0d", hr, mn, m_hr(), m_min()); end
        n_tests++; if (l !== 16'hFFFF) begin n_fail++; $display("FAIL leds_midnight: got %h want ffff", l); end
    endtask

    task automatic test_scan();
        logic [3:0] prev, cur, want;
        int run = 1;
        int changes = 0;
        @(negedge clk);
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cur = an;
            n_tests++; if ($countones(~cur) != 1) begin n_fail++; $display("FAIL scan_onehot: got %b", cur); end
            if (cur === prev) begin
                run++;
            end else begin
                want = {prev[2:0], prev[3]};
                if (changes > 0) begin
                    n_tests++; if (run != REF) begin n_fail++; $display("FAIL scan_dwell: got %0d want %0d", run, REF); end
                end
                n_tests++; if (cur !== want) begin n_fail++; $display("FAIL scan_order: got %b want %b", cur, want); end
                run = 1;
                changes++;
                prev = cur;
            end
        end
        n_tests++; if (changes < 8) begin n_fail++; $display("FAIL scan_changes: got %0d want >=8", changes); end
    endtask

    task automatic test_random();
        int hr, mn, op; logic [6:0] s0, s1; logic [15:0] l;
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(2, 0));
            press(op != 1, op != 0, rand_hold());
            read_display(hr, mn, s0, s1, l);
            n_tests++;
            if (hr !== m_hr() || mn !== m_min() || l !== exp_leds(m_hr())) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d: got %0d:%0d leds %h want %0d:%0d leds %h",
                         i, op, hr, mn, l, m_hr(), m_min(), exp_leds(m_hr()));
            end
        end
    endtask

    task automatic test_midreset();
        int hr, mn; logic [6:0] s0, s1; logic [15:0] l;
        wait_phase(2);
        btn_m = 1'b1;
        repeat (DB / 2) @(negedge clk);
        rst_n = 1'b0;
        btn_m = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (an !== 4'hF || seg !== 7'h7F || leds !== 16'h0) begin
            n_fail++; $display("FAIL midreset_outputs: an %b seg %h leds %h want 1111 7f 0000", an, seg, leds);
        end
        rst_n = 1'b1;
        tod = 0;
        m_done = 0;
        @(negedge clk);
        n_tests++; if (an !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++; $display("FAIL midreset_first: an %b seg %b want 1110 1000000", an, seg);
        end
        read_display(hr, mn, s0, s1, l);
        n_tests++; if (hr !== 0 || mn !== 0) begin n_fail++; $display("FAIL midreset_time: got %0d:%0d want 0:0", hr, mn); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_minutes();
        test_hours();
        test_debounce();
        test_rollover();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
